// File: rtl/hack_mem_arbiter_if.sv
// Bus bundle between the Hack memory arbiter and its CPU, display and memory neighbours.
// The slave modport is the arbiter's view; master is the environment's view.
interface hack_mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic [15:0] cpu_rdata;

  logic        scan_en;
  logic        pix_ready;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_sof;

  logic [14:0] mem_address;
  logic [15:0] mem_in;
  logic        mem_load;
  logic [15:0] mem_out;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, scan_en, pix_ready, mem_out,
    output cpu_gnt, cpu_rdata, pix_valid, pix_data, pix_sof, mem_address, mem_in, mem_load
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, scan_en, pix_ready, mem_out,
    input  cpu_gnt, cpu_rdata, pix_valid, pix_data, pix_sof, mem_address, mem_in, mem_load
  );
endinterface

// File: rtl/hack_mem_arbiter.sv
// Shares one memory port between the CPU (priority, zero-wait when granted) and a screen scanout
// engine feeding a pixel FIFO; fetched words appear one cycle later, a full FIFO stops fetching.
module hack_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input logic               clk,
  input logic               reset,
  hack_mem_arbiter_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  STARVE_C = 4'(STARVE_LIMIT);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t        state, state_nxt;
  logic [12:0]   scan_ptr;
  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    starve;
  logic [16:0]   fifo_mem [FIFO_DEPTH];

  logic scan_want, scan_gnt, cpu_win, flush, push, pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.scan_en)  state_nxt = FETCH;
      FETCH:   if (!bus.scan_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset gates both grants so the memory sees no access while reset is held.
  always_comb begin
    scan_want       = (state == FETCH) && (count < DEPTH_C);
    flush           = (state == FETCH) && !bus.scan_en;
    scan_gnt        = !reset && scan_want && (!bus.cpu_req || starve == STARVE_C);
    cpu_win         = !reset && !scan_gnt && bus.cpu_req;
    bus.cpu_gnt     = cpu_win;
    bus.cpu_rdata   = bus.mem_out;
    bus.mem_address = '0;
    bus.mem_in      = '0;
    bus.mem_load    = 1'b0;
    if (scan_gnt) begin
      bus.mem_address = {2'b10, scan_ptr};
    end else if (cpu_win) begin
      bus.mem_address = bus.cpu_addr;
      bus.mem_in      = bus.cpu_wdata;
      bus.mem_load    = bus.cpu_we;
    end
  end

  // A fetch in the cycle scan_en drops is discarded by the flush.
  assign push = scan_gnt && !flush;
  assign pop  = (count != '0) && bus.pix_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_ptr <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      starve   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (flush) begin
      scan_ptr <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      starve   <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {scan_ptr == 13'd0, bus.mem_out};
        wr_ptr           <= wr_ptr + 1'b1;
        scan_ptr         <= scan_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (scan_gnt || !scan_want)               starve <= '0;
      else if (cpu_win && starve != STARVE_C)   starve <= starve + 1'b1;
    end
  end

  assign bus.pix_valid = (count != '0);
  assign bus.pix_data  = fifo_mem[rd_ptr][15:0];
  assign bus.pix_sof   = fifo_mem[rd_ptr][16];

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Directed bench for hack_mem_arbiter: memory model, scoreboard queues for CPU read data
// and pixel words, immediate assertions at each comparison point.
module tb_hack_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  hack_mem_arbiter_if bus();

  hack_mem_arbiter #(.STARVE_LIMIT(4), .FIFO_DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, registered write; screen word k preloaded with k during reset.
  logic [15:0] ram [32768];
  assign bus.mem_out = ram[bus.mem_address];
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 8192; k++) ram[16384 + k] <= 16'(k);
    end else if (bus.mem_load) begin
      ram[bus.mem_address] <= bus.mem_in;
    end
  end

  logic [16:0] pq[$];
  logic [15:0] cq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pix_check;
    logic [31:0] e;
    if (bus.pix_valid && bus.pix_ready) begin
      e = 32'hDEAD_0000;
      if (pq.size() != 0) e = {15'b0, pq.pop_front()};
      chk("pix_word", {15'b0, bus.pix_sof, bus.pix_data}, e);
    end
  endtask

  initial begin
    int misses;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 15'd5;
    bus.cpu_wdata = 16'h1234;
    bus.scan_en   = 1'b0;
    bus.pix_ready = 1'b0;

    // Reset state, with a CPU request pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_gnt", bus.cpu_gnt, 0);
    chk("rst_mem_load", bus.mem_load, 0);
    chk("rst_mem_address", bus.mem_address, 0);
    chk("rst_mem_in", bus.mem_in, 0);
    chk("rst_pix_valid", bus.pix_valid, 0);
    chk("rst_pix_data", bus.pix_data, 0);
    chk("rst_pix_sof", bus.pix_sof, 0);

    // CPU write then read, no scanout
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("wr_gnt", bus.cpu_gnt, 1);
    chk("wr_load", bus.mem_load, 1);
    chk("wr_addr", bus.mem_address, 5);
    chk("wr_data", bus.mem_in, 16'h1234);
    @(posedge clk); #1 bus.cpu_we = 1'b0;
    cq.push_back(16'h1234);
    @(negedge clk);
    chk("rd_gnt", bus.cpu_gnt, 1);
    chk("rd_load", bus.mem_load, 0);
    chk("rd_data", bus.cpu_rdata, cq.pop_front());
    @(posedge clk); #1 bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("idle_gnt", bus.cpu_gnt, 0);
    chk("idle_addr", bus.mem_address, 0);
    chk("idle_load", bus.mem_load, 0);

    // Full frame plus wrap to word 0
    for (int k = 0; k < 8192; k++) pq.push_back({k == 0, 16'(k)});
    pq.push_back({1'b1, 16'h0000});
    for (int c = 0; c < 8195; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin bus.scan_en = 1'b1; bus.pix_ready = 1'b1; end
      @(negedge clk);
      if (c < 3) chk("first_valid", bus.pix_valid, (c == 2) ? 1 : 0);
      if (c == 1) chk("first_fetch_addr", bus.mem_address, 15'h4000);
      pix_check();
    end
    chk("frame_q_empty", pq.size(), 0);

    // Continuous CPU reads: 4 CPU grants then 1 scan grant
    for (int g = 0; g < 20; g++) begin
      @(posedge clk); #1;
      if (g == 0) begin bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'd5; end
      @(negedge clk);
      chk("grant_pattern", bus.cpu_gnt, ((g % 5) != 4) ? 1 : 0);
      if (bus.cpu_gnt) chk("grant_rdata", bus.cpu_rdata, 16'h1234);
      else             chk("scan_region", bus.mem_address[14:13], 2'b10);
    end

    // Display stalls: FIFO fills, CPU gets every cycle
    for (int f = 0; f < 50; f++) begin
      @(posedge clk); #1;
      if (f == 0) bus.pix_ready = 1'b0;
      @(negedge clk);
    end
    for (int f = 0; f < 8; f++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("full_cpu_gnt", bus.cpu_gnt, 1);
      chk("full_valid", bus.pix_valid, 1);
    end
    @(posedge clk); #1 bus.pix_ready = 1'b1;
    @(negedge clk);
    chk("pulse_cpu_gnt", bus.cpu_gnt, 1);
    misses = 0;
    for (int p = 0; p < 15; p++) begin
      @(posedge clk); #1;
      if (p == 0) bus.pix_ready = 1'b0;
      @(negedge clk);
      if (!bus.cpu_gnt) misses++;
    end
    chk("pulse_fetches", misses, 1);

    // scan_en drop at scan_ptr=100 with words 95..99 buffered
    @(posedge clk); #1 begin bus.cpu_req = 1'b0; bus.scan_en = 1'b0; bus.pix_ready = 1'b0; end
    @(posedge clk); #1;
    @(negedge clk);
    chk("flushed_valid", bus.pix_valid, 0);
    for (int k = 0; k < 95; k++) pq.push_back({k == 0, 16'(k)});
    for (int c = 0; c < 103; c++) begin
      @(posedge clk); #1;
      if (c == 0)   begin bus.scan_en = 1'b1; bus.pix_ready = 1'b1; end
      if (c == 97)  bus.pix_ready = 1'b0;
      if (c == 101) bus.scan_en = 1'b0;
      @(negedge clk);
      if (c <= 96) pix_check();
      if (c == 101) begin
        chk("drop_fetch_addr", bus.mem_address, 15'h4000 + 15'd100);
        chk("drop_head", bus.pix_data, 16'd95);
        chk("drop_head_valid", bus.pix_valid, 1);
      end
      if (c == 102) chk("drop_valid", bus.pix_valid, 0);
    end
    chk("drop_q_empty", pq.size(), 0);

    // Re-enable restarts at word 0 with sof
    pq.push_back({1'b1, 16'd0});
    pq.push_back({1'b0, 16'd1});
    pq.push_back({1'b0, 16'd2});
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin bus.scan_en = 1'b1; bus.pix_ready = 1'b1; end
      @(negedge clk);
      pix_check();
    end
    chk("restart_q_empty", pq.size(), 0);

    // Asynchronous reset between edges mid-scan
    @(posedge clk); #1 begin
      bus.pix_ready = 1'b0; bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
      bus.cpu_addr = 15'd7; bus.cpu_wdata = 16'hBEEF;
    end
    @(negedge clk);
    chk("pre_reset_valid", bus.pix_valid, 1);
    chk("pre_reset_load", bus.mem_load, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_pix_valid", bus.pix_valid, 0);
    chk("arst_pix_data", bus.pix_data, 0);
    chk("arst_pix_sof", bus.pix_sof, 0);
    chk("arst_cpu_gnt", bus.cpu_gnt, 0);
    chk("arst_mem_load", bus.mem_load, 0);
    chk("arst_mem_address", bus.mem_address, 0);
    chk("arst_mem_in", bus.mem_in, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
